apb_controller: RTL
===================

// Module: apb_controller
// PURPOSE
//  APB master sequencer of the AHB-to-APB bridge. Sits between ahb_slave_interface (upstream) and apb_interface (downstream).
//  Turns pipelined AHB transfers (Valid/Hwrite plus registered address/data) into APB SETUP/ENABLE phases.
//  Drives Pwrite/Penable/Pselx/Paddr/Pwdata, stalls AHB via Hreadyout, and returns read data on Hrdata.
// PARAMETERS
//  ADDR_W  32  address width (Haddr*, Paddr)
//  DATA_W  32  data width (Hwdata*, Pwdata, Prdata, Hrdata)
//  NSEL     3  number of one-hot APB slave selects (Tempselx, Pselx)
// PORTS
//  Hclk        in   1       bridge clock; all state updates on rising edge
//  Hresetn     in   1       asynchronous, active-low reset
//  Valid       in   1       AHB transfer in current address phase targets the bridge
//  Hwrite      in   1       direction of current address phase (1=write)
//  Hwritereg   in   1       direction of previous (registered) address phase
//  Haddr       in   ADDR_W  current-phase address
//  Haddr1      in   ADDR_W  address registered one cycle
//  Haddr2      in   ADDR_W  address registered two cycles
//  Hwdata      in   DATA_W  current AHB write data
//  Hwdata1     in   DATA_W  write data registered one cycle
//  Tempselx    in   NSEL    decoded one-hot slave select from upstream
//  Prdata      in   DATA_W  read data returned by apb_interface
//  Pwrite      out  1       APB direction
//  Penable     out  1       APB ENABLE phase
//  Pselx       out  NSEL    APB slave select
//  Paddr       out  ADDR_W  APB address
//  Pwdata      out  DATA_W  APB write data
//  Hreadyout   out  1       0 = stall AHB master
//  Hrdata      out  DATA_W  read data to AHB
// BEHAVIOUR
//  Reset (async, Hresetn=0): state=ST_IDLE; Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hrdata=0, Hreadyout=1.
//   Reset mid-transfer aborts it at once; no partial APB phase survives.
//  Moore FSM. All P* outputs and Hreadyout are registered and loaded from next_state, so they change with the state.
//  Transitions:
//   ST_IDLE:     !Valid->IDLE; Valid&Hwrite->WWAIT; Valid&!Hwrite->READ
//   ST_WWAIT:    !Valid->WRITE; Valid->WRITEP   (one cycle to collect write data)
//   ST_READ:     ->RENABLE
//   ST_WRITE:    !Valid->WENABLE; Valid->WENABLEP
//   ST_WRITEP:   ->WENABLEP
//   ST_RENABLE, ST_WENABLE: same exits as ST_IDLE
//   ST_WENABLEP: !Hwritereg->READ; Hwritereg&!Valid->WRITE; Hwritereg&Valid->WRITEP
//  Registered outputs on entry to each state:
//   READ:   Paddr=Haddr, Pwrite=0, Pselx=Tempselx, Penable=0, Hreadyout=0
//   WWAIT:  all P* held at 0 (Pselx=0, Penable=0); Hreadyout=1
//   WRITE/WRITEP: Paddr=Haddr1 (from WWAIT) or Haddr2 (from WENABLEP); Pwdata=Hwdata;
//     Pwrite=1, Pselx=Tempselx, Penable=0, Hreadyout=0
//   RENABLE/WENABLE/WENABLEP: Penable=1; Paddr, Pwdata, Pwrite, Pselx held; Hreadyout=1
//   IDLE (from ENABLE): Pselx=0, Penable=0, Pwrite=0; Paddr/Pwdata held
//  Hrdata: loaded from Prdata on the edge leaving ST_RENABLE; holds otherwise. Write data is never forwarded to Hrdata.
//  Latency:
//   read: Valid -> SETUP 1 clk -> ENABLE 1 clk; Hrdata valid 3 clks after Valid.
//   write: one extra WWAIT cycle.
//  APB rules:
//   Penable=1 only in a cycle directly after a SETUP cycle with the same Pselx/Paddr.
//   Pselx stays one-hot or zero (Tempselx passed through unchanged).
//  Back-to-back: Valid high in an ENABLE state starts the next SETUP with no idle cycle. Never more than one write pending (WRITEP path).
//  Tempselx=0 while Valid=1 is an upstream error; FSM sequences normally and Pselx=0.
// STRUCTURE
//  Shared package bridge_pkg: state encoding (3-bit localparams ST_IDLE..ST_WENABLEP), ADDR_W/DATA_W/NSEL defaults.
//  Single module: one next-state always block and one registered output always block. No sub-module.
// TESTING
//  1 Reset: Hresetn=0 in ST_WENABLE -> all outputs 0 and Hreadyout=1 in the same cycle; ST_IDLE after release.
//  2 Single read: Valid=1, Hwrite=0, Haddr=0x8000_0010, Tempselx=3'b001, Prdata=0xA5
//     -> SETUP: Pselx=001, Penable=0. Next clk: Penable=1. Then Hrdata=0xA5, back to IDLE.
//  3 Single write: Valid=1, Hwrite=1, Haddr=0x8400_0004, Hwdata=0xDEAD_BEEF
//     -> WWAIT, then Paddr=0x8400_0004, Pwdata=0xDEAD_BEEF, Pwrite=1, Hreadyout=0, then Penable=1.
//  4 Back-to-back writes (Valid held 3 cycles)
//     -> path WWAIT, WRITEP, WENABLEP, WRITEP, WENABLEP, WRITE, WENABLE; Paddr follows Haddr2; no idle gap.
//  5 Write then read (Hwritereg=1, then Hwrite=0)
//     -> WENABLEP then READ; read SETUP directly follows the write ENABLE.
//  6 Protocol checker throughout: Penable never rises without a preceding SETUP; Pselx never multi-hot.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: default widths and the
// APB sequencer state encoding.
package bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NSEL_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  // Exit taken from any state that can accept a fresh AHB transfer.
  function automatic state_t start_exit(input logic valid, input logic hwrite);
    if (!valid)     return ST_IDLE;
    else if (hwrite) return ST_WWAIT;
    else            return ST_READ;
  endfunction

endpackage

// File: rtl/apb_controller.sv
// APB master sequencer of the AHB-to-APB bridge: turns pipelined AHB
// transfers into APB SETUP/ENABLE phases and stalls AHB while they run.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic [NSEL-1:0]   Tempselx,
  input  logic [DATA_W-1:0] Prdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic [NSEL-1:0]   Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic [2:0]        dbg_state
);

  state_t state;
  state_t next_state;

  // Write data is always taken from the live Hwdata bus; the registered copy
  // is part of the upstream interface but not needed here.
  logic unused_hwdata1;
  assign unused_hwdata1 = ^Hwdata1;

  assign dbg_state = state;

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: next_state = start_exit(Valid, Hwrite);
      ST_WWAIT:    next_state = Valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next_state = ST_RENABLE;
      ST_WRITE:    next_state = Valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next_state = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!Hwritereg)  next_state = ST_READ;
        else if (Valid)  next_state = ST_WRITEP;
        else             next_state = ST_WRITE;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  // Outputs are loaded from next_state so they line up with the state register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= ST_IDLE;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Pselx     <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
      Hrdata    <= '0;
    end else begin
      state <= next_state;
      if (state == ST_RENABLE) Hrdata <= Prdata;
      case (next_state)
        ST_READ: begin
          Paddr     <= Haddr;
          Pwrite    <= 1'b0;
          Pselx     <= Tempselx;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          // A write following an ENABLE belongs to the transfer two phases back.
          Paddr     <= (state == ST_WENABLEP) ? Haddr2 : Haddr1;
          Pwdata    <= Hwdata;
          Pwrite    <= 1'b1;
          Pselx     <= Tempselx;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end
        default: begin
          Pselx     <= '0;
          Penable   <= 1'b0;
          Pwrite    <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule
